// File: rtl/compute_pkg.sv
// ---------------------------------------------------------------------------
// compute_pkg
// Shared types and constants for the compute_burst block: the controller
// state enumeration and the memory-request opcode encodings.
// ---------------------------------------------------------------------------
package compute_pkg;

  // Controller states, in the order a normal transfer walks through them
  typedef enum logic [2:0] {
    IDLE,
    READ_REQ,
    READ_DATA,
    WRITE_REQ,
    WRITE_DATA,
    DONE
  } state_t;

  // Memory request opcodes
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/compute_burst_fifo.sv
// ---------------------------------------------------------------------------
// compute_burst_fifo
// Single-clock FIFO that holds the processed beats of one burst between the
// read phase and the write phase.
//
// Parameters:
//   WIDTH  data width in bits
//   DEPTH  number of entries
// Ports:
//   clock      clock
//   reset      synchronous, active-high; empties the FIFO
//   push       write push_data (ignored when full)
//   push_data  data to store
//   pop        drop the head entry (ignored when empty)
//   pop_data   head entry (valid when !empty)
//   full       no free entries
//   empty      no stored entries
// ---------------------------------------------------------------------------
module compute_burst_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Guard the handshakes so a misbehaving caller can never overflow or
  // underflow the occupancy counter
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = storage[rd_ptr];

  // Data storage needs no reset: only entries between the pointers are read
  always_ff @(posedge clock) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/compute_burst.sv
// ---------------------------------------------------------------------------
// compute_burst
// Copies `length` memory beats from inp_baddr to out_baddr in bursts of at
// most BURST_MAX beats, adding `imm` to every LANE_BITS-wide lane of each
// beat on the way through. Each burst is read completely into a local FIFO,
// then written back out, so the FIFO is empty at every burst boundary.
//
// Build option: define COMPUTE_BURST_SATURATE_EN to make the per-lane add
// saturate at 2^LANE_BITS-1 instead of wrapping.
//
// Ports:
//   clock, reset                    clock, synchronous active-high reset
//   mem_req_valid/ready             burst request handshake
//   mem_req_opcode/len/addr         OP_RD/OP_WR, beats-1, byte address
//   mem_wr_valid/ready, mem_wr_bits write beat channel
//   mem_rd_valid/ready, mem_rd_bits read beat channel
//   launch                          start pulse (honoured only in IDLE)
//   finish                          one-cycle done pulse
//   length, inp_baddr, out_baddr    total beats, source and destination base
//   imm                             per-lane addend
// ---------------------------------------------------------------------------
module compute_burst
  import compute_pkg::*;
#(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64,
  parameter int LANE_BITS     = 8,
  parameter int BURST_MAX     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]  mem_req_len,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_wr_valid,
  input  logic                     mem_wr_ready,
  output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  input  logic                     mem_rd_valid,
  output logic                     mem_rd_ready,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  input  logic                     launch,
  output logic                     finish,
  input  logic [31:0]              length,
  input  logic [63:0]              inp_baddr,
  input  logic [63:0]              out_baddr,
  input  logic [LANE_BITS-1:0]     imm
);

  localparam int NL         = MEM_DATA_BITS / LANE_BITS;
  localparam int CNT_W      = MEM_LEN_BITS + 1;
  localparam int BEAT_BYTES = MEM_DATA_BITS / 8;

  state_t                   state;
  state_t                   next_state;
  logic [31:0]              remaining;
  logic [MEM_ADDR_BITS-1:0] rd_addr;
  logic [MEM_ADDR_BITS-1:0] wr_addr;
  logic [LANE_BITS-1:0]     imm_q;
  logic [CNT_W-1:0]         beat_cnt;
  logic [CNT_W-1:0]         burst_n;
  logic                     last_beat;
  logic                     last_burst;
  logic                     rd_fire;
  logic                     wr_fire;
  logic                     finish_q;
  logic [MEM_DATA_BITS-1:0] processed;
  logic [MEM_DATA_BITS-1:0] fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [MEM_ADDR_BITS-1:0] burst_bytes;

  // Burst size only changes when `remaining` drops at the end of a burst, so
  // it is stable for the whole read/write pair of one burst
  assign burst_n     = (remaining > 32'(BURST_MAX)) ? CNT_W'(BURST_MAX) : CNT_W'(remaining);
  assign last_beat   = (beat_cnt == burst_n - CNT_W'(1));
  assign last_burst  = (remaining == 32'(burst_n));
  assign rd_fire     = mem_rd_valid && mem_rd_ready;
  assign wr_fire     = mem_wr_valid && mem_wr_ready;
  assign burst_bytes = MEM_ADDR_BITS'(burst_n) * MEM_ADDR_BITS'(BEAT_BYTES);
  assign finish      = finish_q;

  // Per-lane add of the captured immediate, independent per lane
  for (genvar g = 0; g < NL; g++) begin : g_lane
`ifdef COMPUTE_BURST_SATURATE_EN
    logic [LANE_BITS:0] lane_sum;
    assign lane_sum = {1'b0, mem_rd_bits[g*LANE_BITS +: LANE_BITS]} + {1'b0, imm_q};
    assign processed[g*LANE_BITS +: LANE_BITS] =
      lane_sum[LANE_BITS] ? {LANE_BITS{1'b1}} : lane_sum[LANE_BITS-1:0];
`else
    assign processed[g*LANE_BITS +: LANE_BITS] =
      mem_rd_bits[g*LANE_BITS +: LANE_BITS] + imm_q;
`endif
  end

  compute_burst_fifo #(
    .WIDTH (MEM_DATA_BITS),
    .DEPTH (BURST_MAX)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_fire),
    .push_data (processed),
    .pop       (wr_fire),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a zero-length launch goes straight to DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (launch) next_state = (length == 32'd0) ? DONE : READ_REQ;
      READ_REQ:   if (mem_req_ready) next_state = READ_DATA;
      READ_DATA:  if (rd_fire && last_beat) next_state = WRITE_REQ;
      WRITE_REQ:  if (mem_req_ready) next_state = WRITE_DATA;
      WRITE_DATA: if (wr_fire && last_beat) next_state = last_burst ? DONE : READ_REQ;
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Output decode from the current state; everything idles at zero
  always_comb begin
    mem_req_valid  = 1'b0;
    mem_req_opcode = OP_RD;
    mem_req_len    = '0;
    mem_req_addr   = '0;
    mem_rd_ready   = 1'b0;
    mem_wr_valid   = 1'b0;
    mem_wr_bits    = '0;
    case (state)
      READ_REQ: begin
        mem_req_valid  = 1'b1;
        mem_req_opcode = OP_RD;
        mem_req_len    = MEM_LEN_BITS'(burst_n - CNT_W'(1));
        mem_req_addr   = rd_addr;
      end
      READ_DATA: begin
        mem_rd_ready = !fifo_full;
      end
      WRITE_REQ: begin
        mem_req_valid  = 1'b1;
        mem_req_opcode = OP_WR;
        mem_req_len    = MEM_LEN_BITS'(burst_n - CNT_W'(1));
        mem_req_addr   = wr_addr;
      end
      WRITE_DATA: begin
        mem_wr_valid = !fifo_empty;
        mem_wr_bits  = fifo_empty ? '0 : fifo_head;
      end
      default: ;
    endcase
  end

  // Datapath: operands are captured only on an accepted launch so they stay
  // fixed for the whole transfer. finish is registered off DONE, which puts
  // the pulse one cycle after DONE and two cycles after a zero-length launch.
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining <= '0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      imm_q     <= '0;
      beat_cnt  <= '0;
      finish_q  <= 1'b0;
    end else begin
      finish_q <= (state == DONE);
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (launch) begin
            remaining <= length;
            rd_addr   <= MEM_ADDR_BITS'(inp_baddr);
            wr_addr   <= MEM_ADDR_BITS'(out_baddr);
            imm_q     <= imm;
          end
        end
        READ_DATA: begin
          if (rd_fire) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
          end
        end
        WRITE_DATA: begin
          if (wr_fire) begin
            if (last_beat) begin
              beat_cnt  <= '0;
              remaining <= remaining - 32'(burst_n);
              rd_addr   <= rd_addr + burst_bytes;
              wr_addr   <= wr_addr + burst_bytes;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compute_burst.sv
// ---------------------------------------------------------------------------
// tb_compute_burst
// Self-checking bench for compute_burst with default parameters. A memory
// responder serves read bursts from a synthetic source pattern and a
// scoreboard holds the expected requests and write beats for each launch.
// ---------------------------------------------------------------------------
module tb_compute_burst;
  import compute_pkg::*;

  localparam int LEN_BITS   = 8;
  localparam int ADDR_BITS  = 64;
  localparam int DATA_BITS  = 64;
  localparam int LANE       = 8;
  localparam int BMAX       = 16;
  localparam int BEAT_BYTES = DATA_BITS / 8;

  typedef struct {
    logic                op;
    logic [LEN_BITS-1:0] len;
    logic [63:0]         addr;
  } req_t;

  typedef struct {
    logic [63:0] addr;
    int          avail;
  } rd_t;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 mem_req_valid;
  logic                 mem_req_ready = 1'b0;
  logic                 mem_req_opcode;
  logic [LEN_BITS-1:0]  mem_req_len;
  logic [ADDR_BITS-1:0] mem_req_addr;
  logic                 mem_wr_valid;
  logic                 mem_wr_ready = 1'b0;
  logic [DATA_BITS-1:0] mem_wr_bits;
  logic                 mem_rd_valid = 1'b0;
  logic                 mem_rd_ready;
  logic [DATA_BITS-1:0] mem_rd_bits = '0;
  logic                 launch = 1'b0;
  logic                 finish;
  logic [31:0]          length = '0;
  logic [63:0]          inp_baddr = '0;
  logic [63:0]          out_baddr = '0;
  logic [LANE-1:0]      imm = '0;

  req_t        req_q[$];
  logic [63:0] wdata_q[$];
  rd_t         rd_q[$];
  req_t        resp_req;
  rd_t         resp_rd;

  int          vec_count    = 0;
  int          miscompares  = 0;
  int          cyc          = 0;
  int          finish_count = 0;
  int          finish_cycle = 0;
  int          launch_cycle = 0;
  int          req_seen     = 0;
  int          wr_seen      = 0;
  bit          stall_en     = 1'b0;
  bit          fixed_en     = 1'b0;
  logic [63:0] fixed_word   = '0;

  compute_burst #(
    .MEM_LEN_BITS  (LEN_BITS),
    .MEM_ADDR_BITS (ADDR_BITS),
    .MEM_DATA_BITS (DATA_BITS),
    .LANE_BITS     (LANE),
    .BURST_MAX     (BMAX)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_opcode (mem_req_opcode),
    .mem_req_len    (mem_req_len),
    .mem_req_addr   (mem_req_addr),
    .mem_wr_valid   (mem_wr_valid),
    .mem_wr_ready   (mem_wr_ready),
    .mem_wr_bits    (mem_wr_bits),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_ready   (mem_rd_ready),
    .mem_rd_bits    (mem_rd_bits),
    .launch         (launch),
    .finish         (finish),
    .length         (length),
    .inp_baddr      (inp_baddr),
    .out_baddr      (out_baddr),
    .imm            (imm)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Source memory contents as a function of byte address
  function automatic logic [63:0] src_word(input logic [63:0] a);
    if (fixed_en) return fixed_word;
    return {a[31:0] ^ 32'h5A3C96E1, a[31:0] * 32'h9E3779B1};
  endfunction

  // Reference lane operation
  function automatic logic [63:0] lane_add(input logic [63:0] w, input logic [LANE-1:0] k);
    logic [63:0]   r;
    logic [LANE:0] s;
    r = '0;
    for (int i = 0; i < DATA_BITS / LANE; i++) begin
      s = {1'b0, w[i*LANE +: LANE]} + {1'b0, k};
`ifdef COMPUTE_BURST_SATURATE_EN
      r[i*LANE +: LANE] = s[LANE] ? {LANE{1'b1}} : s[LANE-1:0];
`else
      r[i*LANE +: LANE] = s[LANE-1:0];
`endif
    end
    return r;
  endfunction

  // Launch-to-finish cycles with an always-ready memory
  function automatic int exp_latency(input int len);
    int t;
    int rem;
    int n;
    t   = 2;
    rem = len;
    while (rem > 0) begin
      n   = (rem > BMAX) ? BMAX : rem;
      t   = t + 3 + 2 * n;
      rem = rem - n;
    end
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory responder and output monitor, all sampled on the falling edge
  always @(negedge clock) begin
    if (reset) begin
      mem_req_ready = 1'b0;
      mem_rd_valid  = 1'b0;
      mem_rd_bits   = '0;
      mem_wr_ready  = 1'b0;
    end else begin
      if (mem_req_valid) begin
        req_seen++;
        mem_req_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (mem_req_ready) begin
          if (req_q.size() == 0) begin
            checkOutput("req_spurious", 64'(mem_req_valid), 64'(0));
          end else begin
            resp_req = req_q.pop_front();
            checkOutput("req_opcode", 64'(mem_req_opcode), 64'(resp_req.op));
            checkOutput("req_len", 64'(mem_req_len), 64'(resp_req.len));
            checkOutput("req_addr", 64'(mem_req_addr), resp_req.addr);
            if (mem_req_opcode == OP_RD) begin
              for (int i = 0; i <= int'(mem_req_len); i++) begin
                resp_rd.addr  = mem_req_addr + 64'(i * BEAT_BYTES);
                resp_rd.avail = cyc + 2;
                rd_q.push_back(resp_rd);
              end
            end
          end
        end
      end else begin
        mem_req_ready = 1'b0;
      end

      if (rd_q.size() != 0 && rd_q[0].avail <= cyc &&
          (!stall_en || $urandom_range(0, 3) != 0)) begin
        mem_rd_valid = 1'b1;
        mem_rd_bits  = src_word(rd_q[0].addr);
        if (mem_rd_ready) resp_rd = rd_q.pop_front();
      end else begin
        mem_rd_valid = 1'b0;
      end

      mem_wr_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mem_wr_valid && mem_wr_ready) begin
        wr_seen++;
        if (wdata_q.size() == 0) checkOutput("wr_spurious", 64'(mem_wr_valid), 64'(0));
        else checkOutput("wr_data", mem_wr_bits, wdata_q.pop_front());
      end

      if (finish) begin
        finish_count++;
        finish_cycle = cyc;
      end
    end
  end

  // Push the expected requests and write beats, then pulse launch
  task automatic applyStimulus(input int len, input logic [63:0] ia_in,
                               input logic [63:0] oa_in, input logic [LANE-1:0] k);
    req_t        r;
    logic [63:0] ia;
    logic [63:0] oa;
    int          rem;
    int          n;
    @(negedge clock);
    ia  = ia_in;
    oa  = oa_in;
    rem = len;
    while (rem > 0) begin
      n      = (rem > BMAX) ? BMAX : rem;
      r.len  = LEN_BITS'(n - 1);
      r.op   = OP_RD;
      r.addr = ia;
      req_q.push_back(r);
      r.op   = OP_WR;
      r.addr = oa;
      req_q.push_back(r);
      for (int i = 0; i < n; i++) begin
        wdata_q.push_back(lane_add(src_word(ia + 64'(i * BEAT_BYTES)), k));
      end
      ia  = ia + 64'(n * BEAT_BYTES);
      oa  = oa + 64'(n * BEAT_BYTES);
      rem = rem - n;
    end
    length       = 32'(len);
    inp_baddr    = ia_in;
    out_baddr    = oa_in;
    imm          = k;
    launch       = 1'b1;
    launch_cycle = cyc;
    @(negedge clock);
    launch = 1'b0;
  endtask

  task automatic waitFinish(input int count0);
    int n;
    n = 0;
    while (finish_count == count0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (finish_count == count0) checkOutput("finish_timeout", 64'(0), 64'(1));
  endtask

  // One full transfer with end-of-transfer checks; lat < 0 skips latency
  task automatic runTransfer(input int len, input logic [63:0] ia, input logic [63:0] oa,
                             input logic [LANE-1:0] k, input int lat, input bit poke_launch);
    int f0;
    f0 = finish_count;
    applyStimulus(len, ia, oa, k);
    if (poke_launch) begin
      @(negedge clock);
      length    = 32'd5;
      inp_baddr = 64'hDEAD_0000;
      out_baddr = 64'hBEEF_0000;
      imm       = 8'h77;
      launch    = 1'b1;
      @(negedge clock);
      launch = 1'b0;
    end
    waitFinish(f0);
    repeat (4) @(negedge clock);
    checkOutput("finish_pulses", 64'(finish_count - f0), 64'(1));
    checkOutput("req_left", 64'(req_q.size()), 64'(0));
    checkOutput("wdata_left", 64'(wdata_q.size()), 64'(0));
    checkOutput("rd_left", 64'(rd_q.size()), 64'(0));
    if (lat >= 0) checkOutput("latency", 64'(finish_cycle - launch_cycle), 64'(lat));
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    req_q.delete();
    wdata_q.delete();
    rd_q.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int r0;
    int f0;
    int w0;
    int n;

    applyReset();
    checkOutput("rst_req_valid", 64'(mem_req_valid), 64'(0));
    checkOutput("rst_opcode", 64'(mem_req_opcode), 64'(0));
    checkOutput("rst_len", 64'(mem_req_len), 64'(0));
    checkOutput("rst_addr", 64'(mem_req_addr), 64'(0));
    checkOutput("rst_wr_valid", 64'(mem_wr_valid), 64'(0));
    checkOutput("rst_wr_bits", 64'(mem_wr_bits), 64'(0));
    checkOutput("rst_rd_ready", 64'(mem_rd_ready), 64'(0));
    checkOutput("rst_finish", 64'(finish), 64'(0));

    $display("[TB] single beat, lane 0 wraps");
    fixed_en   = 1'b1;
    fixed_word = 64'h0000_0000_0000_00FF;
    runTransfer(1, 64'h100, 64'h900, 8'h01, exp_latency(1), 1'b0);

    $display("[TB] lane add near the top of the range");
    fixed_word = 64'hFEFE_FEFE_FEFE_FEFE;
    runTransfer(1, 64'h200, 64'hA00, 8'h05, exp_latency(1), 1'b0);
    fixed_en = 1'b0;

    $display("[TB] length 20 splits 16 + 4, launch ignored while busy");
    runTransfer(20, 64'h1000, 64'h2000, 8'h11, exp_latency(20), 1'b1);

    $display("[TB] exact multiple of the burst size, wrapping addresses");
    runTransfer(32, 64'hFFFF_FFFF_FFFF_FF80, 64'h4000, 8'hF0, exp_latency(32), 1'b0);

    $display("[TB] zero length");
    r0 = req_seen;
    runTransfer(0, 64'h3000, 64'h5000, 8'h22, 2, 1'b0);
    checkOutput("len0_requests", 64'(req_seen - r0), 64'(0));

    $display("[TB] random stalls, length 37");
    stall_en = 1'b1;
    runTransfer(37, 64'h1_0000, 64'h8000_0000, 8'h3C, -1, 1'b0);
    stall_en = 1'b0;

    $display("[TB] reset during write phase");
    w0 = wr_seen;
    applyStimulus(10, 64'h6000, 64'h7000, 8'h09);
    n = 0;
    while (wr_seen < w0 + 2 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (wr_seen < w0 + 2) checkOutput("abort_wait_timeout", 64'(0), 64'(1));
    applyReset();
    f0 = finish_count;
    r0 = req_seen;
    repeat (10) @(negedge clock);
    checkOutput("abort_finish", 64'(finish_count - f0), 64'(0));
    checkOutput("abort_requests", 64'(req_seen - r0), 64'(0));
    checkOutput("abort_wr_valid", 64'(mem_wr_valid), 64'(0));
    runTransfer(2, 64'h6100, 64'h7100, 8'h44, exp_latency(2), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
